// File: rtl/text_lcd_if.sv
// Host-side buffer write port of the character LCD controller.
// Handshake: a write or clear is taken on a rising clk edge only when ready=1 in that cycle;
// wr_en/clr_req with ready=0 are dropped, and the host need not hold them until acceptance.
interface text_lcd_if #(
  parameter int AW = 5
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_char;
  logic          clr_req;
  logic          ready;

  modport master (output wr_en, wr_addr, wr_char, clr_req, input ready);
  modport slave  (input wr_en, wr_addr, wr_char, clr_req, output ready);
endinterface

// File: rtl/text_lcd_ctrl.sv
// HD44780-class 8-bit character LCD controller: power-up init, then endless refresh of the
// panel from a LINES x COLS character buffer written by the host.
module text_lcd_ctrl #(
  parameter int TICK_DIV   = 1000,
  parameter int INIT_TICKS = 20,
  parameter int LINES      = 2,
  parameter int COLS       = 16
) (
  input  logic       clk,
  input  logic       rst,
  text_lcd_if.slave  host,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA,
  output logic [7:0] LED_out
);
  localparam int N     = LINES * COLS;
  localparam int AW    = $clog2(N);
  localparam int IW    = (AW > 0) ? AW : 1;
  localparam int TW    = $clog2(TICK_DIV);
  localparam int LW    = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int WW    = $clog2(INIT_TICKS + 4);
  localparam int E_ON  = TICK_DIV / 4;
  localparam int E_OFF = 3 * TICK_DIV / 4;

  typedef enum logic [3:0] {
    S_WAIT  = 4'd0,
    S_FUNC  = 4'd1,
    S_DISP  = 4'd2,
    S_ENTRY = 4'd3,
    S_CLEAR = 4'd4,
    S_ADDR  = 4'd5,
    S_CHAR  = 4'd6
  } state_t;

  function automatic logic [7:0] line_base(input logic [LW-1:0] l);
    case (int'(l))
      0:       line_base = 8'h00;
      1:       line_base = 8'h40;
      2:       line_base = 8'h14;
      default: line_base = 8'h54;
    endcase
  endfunction

  state_t          state_q, state_n;
  logic [TW-1:0]   cnt_q, cnt_n;
  logic [WW-1:0]   wait_q, wait_n;
  logic [LW-1:0]   line_q, line_n;
  logic [CW-1:0]   col_q, col_n;
  logic [3:0]      frame_q, frame_n;
  logic            e_q, e_n, rs_q, rs_n;
  logic [7:0]      data_q, data_n;
  logic            tick_end, strobe;
  logic [IW-1:0]   rd_idx;

  logic [7:0]      char_mem [N];
  logic            sweep_q;
  logic [IW-1:0]   fill_q;
  logic            mem_we;
  logic [IW-1:0]   mem_addr;
  logic [7:0]      mem_din;

  // Next-state and next-output logic; RS/DATA are only reloaded on the tick boundary.
  always_comb begin
    state_n  = state_q;
    wait_n   = wait_q;
    line_n   = line_q;
    col_n    = col_q;
    frame_n  = frame_q;
    rs_n     = rs_q;
    data_n   = data_q;
    rd_idx   = '0;
    tick_end = (cnt_q == TW'(TICK_DIV - 1));
    cnt_n    = tick_end ? '0 : cnt_q + TW'(1);

    if (tick_end) begin
      unique case (state_q)
        S_WAIT: begin
          if (int'(wait_q) >= INIT_TICKS - 1) begin
            state_n = S_FUNC;
            wait_n  = '0;
          end else begin
            wait_n = wait_q + WW'(1);
          end
        end
        S_FUNC:  state_n = S_DISP;
        S_DISP:  state_n = S_ENTRY;
        S_ENTRY: state_n = S_CLEAR;
        S_CLEAR: begin
          // One command tick followed by two idle ticks for the slow clear.
          if (wait_q == WW'(2)) begin
            state_n = S_ADDR;
            wait_n  = '0;
            line_n  = '0;
            col_n   = '0;
          end else begin
            wait_n = wait_q + WW'(1);
          end
        end
        S_ADDR: begin
          state_n = S_CHAR;
          col_n   = '0;
        end
        S_CHAR: begin
          if (col_q == CW'(COLS - 1)) begin
            col_n   = '0;
            state_n = S_ADDR;
            if (line_q == LW'(LINES - 1)) begin
              line_n  = '0;
              frame_n = frame_q + 4'd1;
            end else begin
              line_n = line_q + LW'(1);
            end
          end else begin
            col_n = col_q + CW'(1);
          end
        end
        default: state_n = S_WAIT;
      endcase

      rd_idx = IW'(int'(line_n) * COLS + int'(col_n));
      case (state_n)
        S_FUNC:  begin rs_n = 1'b0; data_n = (LINES > 1) ? 8'h38 : 8'h30; end
        S_DISP:  begin rs_n = 1'b0; data_n = 8'h0C; end
        S_ENTRY: begin rs_n = 1'b0; data_n = 8'h06; end
        S_CLEAR: begin rs_n = 1'b0; data_n = 8'h01; end
        S_ADDR:  begin rs_n = 1'b0; data_n = 8'h80 | line_base(line_n); end
        S_CHAR:  begin rs_n = 1'b1; data_n = char_mem[rd_idx]; end
        default: ;
      endcase
    end

    strobe = (state_n != S_WAIT) && !((state_n == S_CLEAR) && (wait_n != '0));
    e_n    = strobe && (int'(cnt_n) >= E_ON) && (int'(cnt_n) < E_OFF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_WAIT;
      cnt_q   <= '0;
      wait_q  <= '0;
      line_q  <= '0;
      col_q   <= '0;
      frame_q <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      wait_q  <= wait_n;
      line_q  <= line_n;
      col_q   <= col_n;
      frame_q <= frame_n;
      e_q     <= e_n;
      rs_q    <= rs_n;
      data_q  <= data_n;
    end
  end

  // Buffer write port: the space-fill sweep owns the buffer; clear beats a same-cycle write.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = fill_q;
    mem_din  = 8'h20;
    if (sweep_q) begin
      mem_we = 1'b1;
    end else if (host.wr_en && !host.clr_req && (int'(host.wr_addr) < N)) begin
      mem_we   = 1'b1;
      mem_addr = IW'(host.wr_addr);
      mem_din  = host.wr_char;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_q <= 1'b1;
      fill_q  <= '0;
    end else if (sweep_q) begin
      sweep_q <= (fill_q != IW'(N - 1));
      fill_q  <= (fill_q == IW'(N - 1)) ? '0 : fill_q + IW'(1);
    end else if (host.clr_req) begin
      sweep_q <= 1'b1;
      fill_q  <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) char_mem[mem_addr] <= mem_din;
  end

  assign host.ready = ~sweep_q;
  assign LCD_E      = e_q;
  assign LCD_RS     = rs_q;
  assign LCD_RW     = 1'b0;
  assign LCD_DATA   = data_q;
  assign LED_out    = {frame_q, state_q};
endmodule

// File: tb/tb_text_lcd_ctrl.sv
// Self-checking bench for text_lcd_ctrl (TICK_DIV=4, INIT_TICKS=2, 2x4 panel): E pulses are
// matched against an expected queue built from a bench-side model of the character buffer.
module tb_text_lcd_ctrl;
  localparam int TD = 4;
  localparam int IT = 2;
  localparam int LN = 2;
  localparam int CL = 4;
  localparam int N  = LN * CL;
  localparam int NV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       LCD_E, LCD_RS, LCD_RW;
  logic [7:0] LCD_DATA, LED_out;

  // One address bit wider than the buffer needs, so out-of-range indices can be driven.
  text_lcd_if #(.AW(4)) host_if ();

  text_lcd_ctrl #(.TICK_DIV(TD), .INIT_TICKS(IT), .LINES(LN), .COLS(CL)) dut (
    .clk      (clk),
    .rst      (rst),
    .host     (host_if.slave),
    .LCD_E    (LCD_E),
    .LCD_RS   (LCD_RS),
    .LCD_RW   (LCD_RW),
    .LCD_DATA (LCD_DATA),
    .LED_out  (LED_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_fail = 0;
  int cyc;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Scoreboard entries: {rs, data, rise cycle since reset release or 8'hFF = any}.
  logic [16:0] exp_q[$];
  logic [7:0]  exp_mem [N];
  bit          tracking = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pulse monitor: scoreboard pop on each E rise, width/stability check on each fall.
  bit          in_pulse = 0;
  bit          stable = 1;
  bit          rw_bad = 0;
  int          width = 0;
  logic [8:0]  p_val;
  logic [16:0] mon_e;
  always @(negedge clk) begin
    if (LCD_RW !== 1'b0) rw_bad = 1;
    if (rst) begin
      in_pulse = 0;
    end else if (LCD_E === 1'b1) begin
      if (!in_pulse) begin
        in_pulse = 1;
        width    = 1;
        stable   = 1;
        p_val    = {LCD_RS, LCD_DATA};
        if (tracking) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL pulse_extra: got %0h with nothing expected", p_val);
          end else begin
            mon_e = exp_q.pop_front();
            check("pulse_rs_data", 32'(p_val), 32'(mon_e[16:8]));
            if (mon_e[7:0] != 8'hFF) check("pulse_cycle", cyc, 32'(mon_e[7:0]));
          end
        end
      end else begin
        width++;
        if ({LCD_RS, LCD_DATA} != p_val) stable = 0;
      end
    end else if (in_pulse) begin
      in_pulse = 0;
      check("pulse_width", width, 2);
      check("pulse_stable", 32'(stable), 1);
    end
  end

  // Frame counter must step by one (mod 16) at every change outside reset.
  logic [3:0] prev_frame = 4'd0;
  logic [3:0] next_frame;
  bit         wrap_seen = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_frame = 4'd0;
    end else if (LED_out[7:4] != prev_frame) begin
      next_frame = prev_frame + 4'd1;
      check("frame_step", 32'(LED_out[7:4]), 32'(next_frame));
      if (prev_frame == 4'hF && LED_out[7:4] == 4'h0) wrap_seen = 1;
      prev_frame = LED_out[7:4];
    end
  end

  task automatic drive_idle();
    host_if.wr_en   = 1'b0;
    host_if.clr_req = 1'b0;
    host_if.wr_addr = '0;
    host_if.wr_char = '0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_timeout: %0d pulses pending after %0d cycles", name, exp_q.size(), n);
      exp_q.delete();
    end
    tracking = 0;
  endtask

  // Called with rst high; releases it and checks ready timing plus the full init sequence.
  task automatic run_init();
    for (int i = 0; i < N; i++) exp_mem[i] = 8'h20;
    exp_q.push_back({1'b0, 8'h38, 8'd9});
    exp_q.push_back({1'b0, 8'h0C, 8'd13});
    exp_q.push_back({1'b0, 8'h06, 8'd17});
    exp_q.push_back({1'b0, 8'h01, 8'd21});
    exp_q.push_back({1'b0, 8'h80, 8'd33});
    tracking = 1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_outputs", 32'({LCD_E, LCD_RS, LCD_DATA, LED_out, host_if.ready}), 0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("ready_cycle7", 32'(host_if.ready), 0);
    @(negedge clk);
    check("ready_cycle8", 32'(host_if.ready), 1);
    drain("init");
  endtask

  task automatic frame_check(input string name);
    logic [3:0] f0;
    int n = 0;
    exp_q.push_back({1'b0, 8'h80, 8'hFF});
    for (int c = 0; c < CL; c++) exp_q.push_back({1'b1, exp_mem[c], 8'hFF});
    exp_q.push_back({1'b0, 8'hC0, 8'hFF});
    for (int c = 0; c < CL; c++) exp_q.push_back({1'b1, exp_mem[CL + c], 8'hFF});
    @(negedge clk);
    f0 = LED_out[7:4];
    while (LED_out[7:4] == f0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (LED_out[7:4] == f0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_sync: frame count stuck at %0d", name, f0);
      exp_q.delete();
    end else begin
      tracking = 1;
      drain(name);
    end
  endtask

  typedef struct {
    logic       wr_en;
    logic       clr;
    logic [3:0] addr;
    logic [7:0] ch;
    logic       exp_ready;
    logic       check_frame;
  } vec_t;
  vec_t vecs [NV];

  initial begin
    int n;
    vecs[0]  = '{1'b1, 1'b0, 4'd0,  8'h41, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 4'd1,  8'h42, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 4'd7,  8'h5A, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 4'd9,  8'h51, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 4'd12, 8'h52, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 4'd2,  8'h57, 1'b1, 1'b0};
    for (int i = 6; i < 14; i++) vecs[i] = '{1'b1, 1'b0, 4'd0, 8'h58, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 4'd5,  8'h4D, 1'b1, 1'b1};

    drive_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          32'({LCD_E, LCD_RS, LCD_RW, LCD_DATA, LED_out, host_if.ready}), 0);

    run_init();

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      host_if.wr_en   = vecs[i].wr_en;
      host_if.clr_req = vecs[i].clr;
      host_if.wr_addr = vecs[i].addr;
      host_if.wr_char = vecs[i].ch;
      check($sformatf("ready_vec%0d", i), 32'(host_if.ready), 32'(vecs[i].exp_ready));
      if (vecs[i].exp_ready && vecs[i].clr) begin
        for (int k = 0; k < N; k++) exp_mem[k] = 8'h20;
      end else if (vecs[i].exp_ready && vecs[i].wr_en && (int'(vecs[i].addr) < N)) begin
        exp_mem[vecs[i].addr[2:0]] = vecs[i].ch;
      end
      if (vecs[i].check_frame) begin
        @(posedge clk);
        #1 drive_idle();
        frame_check($sformatf("frame_vec%0d", i));
      end
    end
    @(posedge clk);
    #1 drive_idle();

    repeat (17 * 40) @(posedge clk);
    check("frame_wrap_seen", 32'(wrap_seen), 1);

    // Reset for one cycle in the first cycle of an S_CHAR enable pulse.
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(LCD_E === 1'b1 && LED_out[3:0] == 4'd6) && n < 200);
    if (n >= 200) begin
      n_vec++;
      n_fail++;
      $display("FAIL char_pulse_search: no S_CHAR pulse within %0d cycles", n);
    end
    rst = 1'b1;
    run_init();
    frame_check("frame_after_rst");

    check("lcd_rw_zero", 32'(rw_bad), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
